// File: rtl/result_transfer.sv
`default_nettype none
// ============================================================================
// Module   : result_transfer
// Purpose  : Byte-serial transmitter returning classifier results to the Pi.
//            Snapshots a NUM_BYTES result vector on start, then offers one
//            byte at a time on dataRegister, paced by the Pi through the
//            two-bit PI_STATE / FPGA_STATE handshake.
// Options  : RESULT_TX_CHECKSUM_EN - when defined, appends a modulo-256 sum
//            of the buffered bytes as one extra trailing byte.
// Revision : 1.0 - initial release
// ============================================================================
module result_transfer #(
  parameter int NUM_BYTES = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_BYTES-1:0][7:0] result,
  input  logic                      start,
  input  logic                      writeEnable,
  input  logic [1:0]                PI_STATE,
  output logic [7:0]                dataRegister,
  output logic [1:0]                FPGA_STATE,
  output logic                      busy,
  output logic                      done,
  output logic                      aborted
);

  localparam int IDX_W = $clog2(NUM_BYTES + 1);

  // The checksum byte sits one slot past the last result byte.
`ifdef RESULT_TX_CHECKSUM_EN
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES);
`else
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
`endif

  // FPGA-side states; the encoding is what the Pi sees on FPGA_STATE.
  localparam logic [1:0] S_IDLE      = 2'b11;
  localparam logic [1:0] S_PRESENT   = 2'b10;
  localparam logic [1:0] S_SENT_BYTE = 2'b01;
  localparam logic [1:0] S_SENT_ALL  = 2'b00;

  // Pi-side handshake codes that move this block.
  localparam logic [1:0] PI_READY    = 2'b01;
  localparam logic [1:0] PI_CONTINUE = 2'b11;
  localparam logic [1:0] PI_DONE     = 2'b10;

  logic [1:0]                state;
  logic [IDX_W-1:0]          idx;
  logic [NUM_BYTES-1:0][7:0] result_buf;
  logic [IDX_W-1:0]          next_idx;
  logic [7:0]                next_byte;

  // A qualified PI_STATE code; PI_STATE is meaningless while writeEnable is low.
  logic pi_ready;
  logic pi_continue;
  logic pi_done;

  assign pi_ready    = writeEnable && (PI_STATE == PI_READY);
  assign pi_continue = writeEnable && (PI_STATE == PI_CONTINUE);
  assign pi_done     = writeEnable && (PI_STATE == PI_DONE);

  assign FPGA_STATE = state;

`ifdef RESULT_TX_CHECKSUM_EN
  logic [7:0] result_sum;
  logic [7:0] checksum;

  // Modulo-256 sum of the incoming vector, captured alongside the buffer.
  always_comb begin
    result_sum = 8'h00;
    for (int k = 0; k < NUM_BYTES; k++) begin
      result_sum = result_sum + result[k];
    end
  end
`endif

  // Select the byte for the following index; a decode loop keeps the select
  // well-defined for every NUM_BYTES, including the single-byte case.
  always_comb begin
    next_idx  = idx + IDX_W'(1);
    next_byte = 8'h00;
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (next_idx == IDX_W'(k)) begin
        next_byte = result_buf[k];
      end
    end
`ifdef RESULT_TX_CHECKSUM_EN
    if (next_idx == LAST_IDX) begin
      next_byte = checksum;
    end
`endif
  end

  // Handshake state machine, byte buffer and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      idx          <= '0;
      result_buf   <= '0;
      dataRegister <= 8'h00;
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
`ifdef RESULT_TX_CHECKSUM_EN
      checksum     <= 8'h00;
`endif
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            result_buf   <= result;
            idx          <= '0;
            dataRegister <= result[0];
            busy         <= 1'b1;
            state        <= S_PRESENT;
`ifdef RESULT_TX_CHECKSUM_EN
            checksum     <= result_sum;
`endif
          end
        end
        S_PRESENT: begin
          if (pi_ready) begin
            state <= (idx == LAST_IDX) ? S_SENT_ALL : S_SENT_BYTE;
          end
        end
        S_SENT_BYTE: begin
          // idx is always below LAST_IDX here, so the increment cannot wrap.
          if (pi_continue) begin
            idx          <= next_idx;
            dataRegister <= next_byte;
            state        <= S_PRESENT;
          end else if (pi_done) begin
            busy    <= 1'b0;
            aborted <= 1'b1;
            state   <= S_IDLE;
          end
        end
        default: begin // S_SENT_ALL
          if (pi_done) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/result_transfer.md
# result_transfer

Byte-serial transmitter that returns classifier results from the FPGA to the Raspberry Pi. It uses the same two-bit PI_STATE / FPGA_STATE handshake as the inbound image path, with the roles reversed: the FPGA presents bytes and the Pi consumes them. On `start` it snapshots a parameterised result vector, such as ten per-class scores. It then places one byte at a time on `dataRegister`, advancing only on Pi acknowledgements. It sits between the classifier output stage and the GPIO pins to the Pi.

## Interface
- NUM_BYTES, 10, number of result bytes per transfer (1..256)
- clk  in  1  system clock, all logic on posedge
- reset  in  1  asynchronous, active-low reset
- result  in  [NUM_BYTES-1:0][7:0]  result vector, sampled only on accepted `start`
- start  in  1  request to send `result`; honoured only in IDLE
- writeEnable  in  1  qualifies PI_STATE; PI_STATE is ignored while low
- PI_STATE  in  2  Pi handshake: BUSY=00, READY=01, CONTINUE=11, DONE=10 (already synchronised upstream)
- dataRegister  out  8  byte currently offered to the Pi
- FPGA_STATE  out  2  current state encoding, driven directly from the state register
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse on normal completion
- aborted  out  1  one-cycle pulse on Pi-initiated abort

## Operation
- **IDLE (11).**
  - `start`=1: copy `result` into the internal buffer, set index to 0, load `dataRegister` = buffer[0], go to PRESENT.
  - Otherwise stay in IDLE.
- **PRESENT (10).** The byte at the current index is valid on `dataRegister`.
  - `writeEnable`=1 and PI_STATE=READY (the Pi has latched the byte):
    - go to SENT_ALL if index = last index;
    - otherwise go to SENT_BYTE.
  - All other PI_STATE values: hold.
- **SENT_BYTE (01).**
  - `writeEnable`=1 and PI_STATE=CONTINUE: increment index, load the next byte into `dataRegister`, go to PRESENT.
  - `writeEnable`=1 and PI_STATE=DONE: go to IDLE and pulse `aborted`.
  - READY or BUSY: hold. A held READY must never advance twice.
- **SENT_ALL (00).**
  - `writeEnable`=1 and PI_STATE=DONE: go to IDLE and pulse `done`.
  - CONTINUE, READY or BUSY: hold.
- `start` while `busy`: ignored. The buffer is not reloaded.
- `result` changes after a `start` is accepted: no effect on the transfer in progress.
- Last index is NUM_BYTES-1, or NUM_BYTES when the checksum is enabled.
- Index width is $clog2(NUM_BYTES+1). It never wraps: index does not advance past the last index.
- `dataRegister` holds its last value in SENT_BYTE, SENT_ALL and IDLE. It changes only on a load.

## Timing
- **Reset values** (asserted at any time, including mid-transfer): FPGA_STATE=11, `dataRegister`=8'h00, index=0, `busy`=0, `done`=0, `aborted`=0. There is no partial-transfer recovery.
- All outputs are registered.
- **`start` to first byte.** `start` sampled at edge N gives FPGA_STATE=10 and `dataRegister`=byte 0 after edge N.
- **Per-byte handshake.** READY sampled moves to 01 one cycle later. CONTINUE sampled moves to 10 with the new byte one cycle later. Minimum 2 cycles per byte.
- **Completion.** `done` or `aborted` is high for exactly the one cycle in which FPGA_STATE first reads 11. `busy` falls on the same edge.
- **Back-to-back transfers.** `start` is accepted on the cycle after the return to IDLE.

## Configuration
- **RESULT_TX_CHECKSUM_EN defined.**
  - One extra byte is sent after byte NUM_BYTES-1: the modulo-256 sum of all NUM_BYTES buffered bytes.
  - The sum is computed when `start` is accepted.
  - The transfer is NUM_BYTES+1 bytes. SENT_ALL is entered only after the checksum byte is acknowledged with READY.
- **Undefined.** Exactly NUM_BYTES bytes are sent, and no checksum logic is instantiated.

## Test plan
- **Reset mid-transfer.** Assert reset in SENT_BYTE at index 4 -> FPGA_STATE=11, `dataRegister`=00 and `busy`=0 immediately. A following `start` sends from byte 0.
- **Normal transfer.** NUM_BYTES=10, result[k]=8'h10+k. Pi loops READY/CONTINUE, then DONE -> Pi reads 10..19 in order, FPGA_STATE ends 00 then 11, `done` pulses exactly once.
- **Checksum on.** Same stimulus with RESULT_TX_CHECKSUM_EN -> an 11th byte 8'hCD precedes SENT_ALL.
- **Stalls and gating.** Hold READY for 5 cycles in SENT_BYTE, drop `writeEnable` during CONTINUE, pulse `start` mid-transfer -> index advances by exactly one per READY/CONTINUE pair. Ignored `start` changes neither the buffer nor the state.
- **Abort.** PI_STATE=DONE in SENT_BYTE after byte 3 -> FPGA_STATE=11, `aborted` pulses once, `done` stays 0.
- **Edge size and back-to-back.** NUM_BYTES=1, result=8'hA5 -> 10 → 00 (after READY) → 11 (after DONE). A `start` the next cycle, with result=8'h5A, presents 5A.
